// File: rtl/falu_clk_rst_pkg.sv
// falu_clk_rst_pkg: shared types and defaults for the FALU clock/reset sequencer.
//   state_t              - sequencer states (2-bit encoding, all codes used)
//   DEF_SYNC_STAGES      - default pll_locked synchronizer depth
//   DEF_LOCK_STABLE_CYC  - default lock qualification length (cycles)
//   DEF_RST_STAGGER_CYC  - default core->periph release stagger (cycles)
//   max_int()            - elaboration helper for sizing counters
package falu_clk_rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_QUALIFY = 2'd1,
    S_STAGGER = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_LOCK_STABLE_CYC = 1024;
  localparam int DEF_RST_STAGGER_CYC = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/falu_bit_sync.sv
// falu_bit_sync: single-bit multi-flop synchronizer for FALU CDC points.
//   clk   - destination clock
//   rst   - async active-high reset, chain clears to 0
//   i_d   - asynchronous input bit
//   o_q   - synchronized output (SYNC_STAGES clk edges of latency)
module falu_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/falu_clk_rst_seq.sv
// falu_clk_rst_seq: qualifies PLL lock and sequences resets into the FALU
// clock domain. Resets assert asynchronously (rst) or on synchronized lock
// loss; they release synchronously: core first, periph after a stagger, then
// clk_ready. All outputs are registered.
//   clk        - FALU clock (PLL outclk_0)
//   rst        - async active-high reset
//   pll_locked - PLL lock flag, asynchronous to clk
//   core_rst   - FALU datapath reset (active high)
//   periph_rst - FALU interface/handshake reset (active high)
//   clk_ready  - sequence complete and lock held
//   lock_lost  - one-cycle pulse when a qualified lock is lost
//   loss_count - saturating lock-loss count (only with FALU_RST_LOSS_CNT_EN)
// Optional feature macro: FALU_RST_LOSS_CNT_EN
import falu_clk_rst_pkg::*;

module falu_clk_rst_seq #(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYC,
  parameter int RST_STAGGER_CYCLES = DEF_RST_STAGGER_CYC,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic core_rst,
  output logic periph_rst,
  output logic clk_ready,
  output logic lock_lost
`ifdef FALU_RST_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] loss_count
`endif
);

  if (SYNC_STAGES < 2)        begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");        end
  if (LOCK_STABLE_CYCLES < 1) begin : g_bad_lock  $error("LOCK_STABLE_CYCLES must be >= 1"); end
  if (RST_STAGGER_CYCLES < 1) begin : g_bad_stag  $error("RST_STAGGER_CYCLES must be >= 1"); end
  if (LOSS_CNT_W < 1)         begin : g_bad_lossw $error("LOSS_CNT_W must be >= 1");         end

  localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, RST_STAGGER_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(RST_STAGGER_CYCLES - 1);

  logic       w_lk;
  state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic       r_core_rst, w_core_nxt;
  logic       r_periph_rst, w_per_nxt;
  logic       r_clk_ready, w_rdy_nxt;
  logic       r_lock_lost, w_ll_nxt;

  falu_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_HOLD;
      r_cnt        <= '0;
      r_core_rst   <= 1'b1;
      r_periph_rst <= 1'b1;
      r_clk_ready  <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_core_rst   <= w_core_nxt;
      r_periph_rst <= w_per_nxt;
      r_clk_ready  <= w_rdy_nxt;
      r_lock_lost  <= w_ll_nxt;
    end
  end

  // Lock loss always wins over counter completion, so a drop on the very
  // cycle a count finishes still returns to S_HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_core_nxt  = r_core_rst;
    w_per_nxt   = r_periph_rst;
    w_rdy_nxt   = r_clk_ready;
    w_ll_nxt    = 1'b0;
    case (r_state)
      S_HOLD: begin
        w_core_nxt = 1'b1;
        w_per_nxt  = 1'b1;
        w_rdy_nxt  = 1'b0;
        w_cnt_nxt  = '0;
        if (w_lk) w_state_nxt = S_QUALIFY;
      end
      S_QUALIFY: begin
        if (!w_lk) begin
          // never qualified, so no lock_lost pulse
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == QUAL_LAST) begin
          w_state_nxt = S_STAGGER;
          w_core_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STAGGER: begin
        if (!w_lk) begin
          w_state_nxt = S_HOLD;
          w_core_nxt  = 1'b1;
          w_per_nxt   = 1'b1;
          w_rdy_nxt   = 1'b0;
          w_ll_nxt    = 1'b1;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STAG_LAST) begin
          w_state_nxt = S_RUN;
          w_per_nxt   = 1'b0;
          w_rdy_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!w_lk) begin
          w_state_nxt = S_HOLD;
          w_core_nxt  = 1'b1;
          w_per_nxt   = 1'b1;
          w_rdy_nxt   = 1'b0;
          w_ll_nxt    = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_core_nxt  = 1'b1;
        w_per_nxt   = 1'b1;
        w_rdy_nxt   = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign core_rst   = r_core_rst;
  assign periph_rst = r_periph_rst;
  assign clk_ready  = r_clk_ready;
  assign lock_lost  = r_lock_lost;

`ifdef FALU_RST_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  // Counts on the same edge that registers the lock_lost pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_loss_cnt <= '0;
    else if (w_ll_nxt && !(&r_loss_cnt))  r_loss_cnt <= r_loss_cnt + 1'b1;
  end

  assign loss_count = r_loss_cnt;
`endif

endmodule

// File: tb/tb_falu_clk_rst_seq.sv
// tb_falu_clk_rst_seq: self-checking bench for falu_clk_rst_seq.
// Reference model: synchronized lock is pll_locked delayed SYNC_STAGES edges;
// the sequencer is described by the length of the current unbroken lock run.
module tb_falu_clk_rst_seq;

  localparam int SS = 2;
  localparam int LS = 8;
  localparam int RS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic core_rst, periph_rst, clk_ready, lock_lost;
`ifdef FALU_RST_LOSS_CNT_EN
  logic [1:0] loss_count;
`endif

  int total = 0;
  int bad   = 0;

  falu_clk_rst_seq #(
    .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(LS), .RST_STAGGER_CYCLES(RS), .LOSS_CNT_W(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .core_rst   (core_rst),
    .periph_rst (periph_rst),
    .clk_ready  (clk_ready),
    .lock_lost  (lock_lost)
`ifdef FALU_RST_LOSS_CNT_EN
    ,
    .loss_count (loss_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // core released once the lock run exceeds LS edges, periph once it exceeds
  // LS+RS; a loss after core release is a reported loss.
  logic [SS-1:0] m_sh;
  int            m_run;
  logic          m_core, m_per, m_ll;
  logic [1:0]    m_loss;

  function automatic int nrun(input int r, input logic lk);
    return lk ? r + 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sh <= '0; m_run <= 0; m_core <= 1'b1; m_per <= 1'b1; m_ll <= 1'b0; m_loss <= 2'd0;
    end else begin
      m_sh   <= {m_sh[SS-2:0], pll_locked};
      m_run  <= nrun(m_run, m_sh[SS-1]);
      m_core <= (nrun(m_run, m_sh[SS-1]) < LS + 1);
      m_per  <= (nrun(m_run, m_sh[SS-1]) < LS + RS + 1);
      m_ll   <= !m_sh[SS-1] && (m_run >= LS + 1);
      if (!m_sh[SS-1] && (m_run >= LS + 1) && m_loss != 2'd3) m_loss <= m_loss + 2'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pll_locked = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0;
    step(); step();
    total++; if (core_rst !== 1'b1)   begin bad++; $display("FAIL reset_core got=%b exp=1", core_rst); end
    total++; if (periph_rst !== 1'b1) begin bad++; $display("FAIL reset_periph got=%b exp=1", periph_rst); end
    total++; if (clk_ready !== 1'b0)  begin bad++; $display("FAIL reset_ready got=%b exp=0", clk_ready); end
    total++; if (lock_lost !== 1'b0)  begin bad++; $display("FAIL reset_lost got=%b exp=0", lock_lost); end
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      step();
      total++;
      if ({core_rst, periph_rst, clk_ready, lock_lost} !== 4'b1100) begin
        bad++; $display("FAIL idle_nolock k=%0d got=%b exp=1100", k, {core_rst, periph_rst, clk_ready, lock_lost});
      end
    end
  endtask

  task automatic test_sequence();
    do_reset();
    pll_locked = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++; if (core_rst !== (k < 11))   begin bad++; $display("FAIL seq_core k=%0d got=%b exp=%b", k, core_rst, (k < 11)); end
      total++; if (periph_rst !== (k < 15)) begin bad++; $display("FAIL seq_periph k=%0d got=%b exp=%b", k, periph_rst, (k < 15)); end
      total++; if (clk_ready !== (k >= 15)) begin bad++; $display("FAIL seq_ready k=%0d got=%b exp=%b", k, clk_ready, (k >= 15)); end
      total++; if (lock_lost !== 1'b0)      begin bad++; $display("FAIL seq_lost k=%0d got=%b exp=0", k, lock_lost); end
      total++; if (!periph_rst && core_rst) begin bad++; $display("FAIL seq_inv k=%0d core=%b periph=%b", k, core_rst, periph_rst); end
    end
  endtask

  task automatic test_qualify_drop();
    do_reset();
    pll_locked = 1'b1;
    repeat (6) step();
    pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (lock_lost !== 1'b0 || core_rst !== 1'b1) begin
        bad++; $display("FAIL qual_drop k=%0d lost=%b core=%b exp lost=0 core=1", k, lock_lost, core_rst);
      end
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      total++; if (core_rst !== (k < 11)) begin bad++; $display("FAIL qual_relock_core k=%0d got=%b exp=%b", k, core_rst, (k < 11)); end
      total++; if (lock_lost !== 1'b0)    begin bad++; $display("FAIL qual_relock_lost k=%0d got=%b exp=0", k, lock_lost); end
    end
  endtask

  task automatic test_loss();
    do_reset();
    pll_locked = 1'b1;
    repeat (20) step();
    pll_locked = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      total++; if (core_rst !== (k >= 3))   begin bad++; $display("FAIL run_loss_core k=%0d got=%b exp=%b", k, core_rst, (k >= 3)); end
      total++; if (periph_rst !== (k >= 3)) begin bad++; $display("FAIL run_loss_periph k=%0d got=%b exp=%b", k, periph_rst, (k >= 3)); end
      total++; if (clk_ready !== (k < 3))   begin bad++; $display("FAIL run_loss_ready k=%0d got=%b exp=%b", k, clk_ready, (k < 3)); end
      total++; if (lock_lost !== (k == 3))  begin bad++; $display("FAIL run_loss_pulse k=%0d got=%b exp=%b", k, lock_lost, (k == 3)); end
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      total++; if (core_rst !== (k < 11))   begin bad++; $display("FAIL relock_core k=%0d got=%b exp=%b", k, core_rst, (k < 11)); end
      total++; if (periph_rst !== (k < 15)) begin bad++; $display("FAIL relock_periph k=%0d got=%b exp=%b", k, periph_rst, (k < 15)); end
    end
    // drop inside the stagger window
    pll_locked = 1'b0;
    repeat (4) step();
    pll_locked = 1'b1;
    repeat (11) step();
    pll_locked = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (core_rst !== (k >= 3))  begin bad++; $display("FAIL stag_loss_core k=%0d got=%b exp=%b", k, core_rst, (k >= 3)); end
      total++; if (periph_rst !== 1'b1)    begin bad++; $display("FAIL stag_loss_periph k=%0d got=%b exp=1", k, periph_rst); end
      total++; if (clk_ready !== 1'b0)     begin bad++; $display("FAIL stag_loss_ready k=%0d got=%b exp=0", k, clk_ready); end
      total++; if (lock_lost !== (k == 3)) begin bad++; $display("FAIL stag_loss_pulse k=%0d got=%b exp=%b", k, lock_lost, (k == 3)); end
    end
  endtask

  task automatic test_async_rst();
    do_reset();
    pll_locked = 1'b1;
    repeat (12) step();
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL arst_pre_core got=%b exp=0", core_rst); end
    #2 rst = 1'b1;
    #1;
    total++; if (core_rst !== 1'b1)   begin bad++; $display("FAIL arst_core got=%b exp=1", core_rst); end
    total++; if (periph_rst !== 1'b1) begin bad++; $display("FAIL arst_periph got=%b exp=1", periph_rst); end
    total++; if (clk_ready !== 1'b0)  begin bad++; $display("FAIL arst_ready got=%b exp=0", clk_ready); end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      total++; if (core_rst !== (k < 11))   begin bad++; $display("FAIL arst_seq_core k=%0d got=%b exp=%b", k, core_rst, (k < 11)); end
      total++; if (periph_rst !== (k < 15)) begin bad++; $display("FAIL arst_seq_periph k=%0d got=%b exp=%b", k, periph_rst, (k < 15)); end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = pll_locked ? $urandom_range(1, 30) : $urandom_range(1, 6);
      end
      hold--;
      step();
      total++;
      if ({core_rst, periph_rst, clk_ready, lock_lost} !== {m_core, m_per, !m_per, m_ll}) begin
        bad++; $display("FAIL rand n=%0d got=%b exp=%b", n, {core_rst, periph_rst, clk_ready, lock_lost},
                        {m_core, m_per, !m_per, m_ll});
      end
`ifdef FALU_RST_LOSS_CNT_EN
      total++; if (loss_count !== m_loss) begin bad++; $display("FAIL rand_loss n=%0d got=%0d exp=%0d", n, loss_count, m_loss); end
`endif
    end
    rst = 1'b0;
  endtask

`ifdef FALU_RST_LOSS_CNT_EN
  task automatic test_loss_count();
    logic [1:0] exp;
    do_reset();
    total++; if (loss_count !== 2'd0) begin bad++; $display("FAIL lcnt_init got=%0d exp=0", loss_count); end
    for (int n = 1; n <= 5; n++) begin
      pll_locked = 1'b1;
      repeat (16) step();
      pll_locked = 1'b0;
      repeat (3) step();
      exp = (n < 3) ? 2'(n) : 2'd3;
      total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL lcnt_pulse n=%0d got=%b exp=1", n, lock_lost); end
      total++; if (loss_count !== exp) begin bad++; $display("FAIL lcnt n=%0d got=%0d exp=%0d", n, loss_count, exp); end
      step();
    end
    rst = 1'b1;
    #1;
    total++; if (loss_count !== 2'd0) begin bad++; $display("FAIL lcnt_clear got=%0d exp=0", loss_count); end
    step();
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_qualify_drop();
    test_loss();
    test_async_rst();
`ifdef FALU_RST_LOSS_CNT_EN
    test_loss_count();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
